// File: rtl/frame_hdr_extract_if.sv
// Bundles the pointer/data FIFO read ports, output byte stream and header
// descriptor handshake of frame_hdr_extract. master is the extractor side.
interface frame_hdr_extract_if;
  logic        ptr_sfifo_empty;
  logic        ptr_sfifo_rd;
  logic [15:0] ptr_sfifo_dout;
  logic        sfifo_rd;
  logic [7:0]  sfifo_dout;
  logic        out_space_ok;
  logic        out_data_wr;
  logic [7:0]  out_data;
  logic        out_sof;
  logic        out_eof;
  logic        hdr_valid;
  logic        hdr_ack;
  logic [47:0] hdr_dmac;
  logic [47:0] hdr_smac;
  logic [3:0]  hdr_src_port;
  logic [10:0] hdr_len;
  logic        drop_pulse;

  modport master (
    input  ptr_sfifo_empty, ptr_sfifo_dout, sfifo_dout, out_space_ok, hdr_ack,
    output ptr_sfifo_rd, sfifo_rd, out_data_wr, out_data, out_sof, out_eof,
           hdr_valid, hdr_dmac, hdr_smac, hdr_src_port, hdr_len, drop_pulse
  );

  modport slave (
    output ptr_sfifo_empty, ptr_sfifo_dout, sfifo_dout, out_space_ok, hdr_ack,
    input  ptr_sfifo_rd, sfifo_rd, out_data_wr, out_data, out_sof, out_eof,
           hdr_valid, hdr_dmac, hdr_smac, hdr_src_port, hdr_len, drop_pulse
  );
endinterface

// File: rtl/frame_hdr_extract.sv
// Pops one frame descriptor plus its bytes, streams accepted frames out,
// extracts DMAC/SMAC and presents a header descriptor; bad frames are drained.
module frame_hdr_extract #(
  parameter int unsigned MIN_LEN = 60,
  parameter int unsigned MAX_LEN = 1518
) (
  input  logic                 clk_sys,
  input  logic                 rstn_sys,
  frame_hdr_extract_if.master  bus
);

  localparam logic [10:0] MIN_L = 11'(MIN_LEN);
  localparam logic [10:0] MAX_L = 11'(MAX_LEN);

  typedef enum logic [2:0] {IDLE, PTR_RD, PTR_CAP, DATA, DRAIN, HDR} state_t;

  state_t      state_q, state_d;
  logic        boot_q, boot_d;
  logic        drop_q, drop_d;
  logic        wr_q, wr_d;
  logic [10:0] cnt_q, cnt_d;
  logic [10:0] len_q, len_d;
  logic [3:0]  port_q, port_d;
  logic [3:0]  hidx_q, hidx_d;
  logic [47:0] dmac_q, dmac_d;
  logic [47:0] smac_q, smac_d;

  logic        desc_err;
  logic [3:0]  desc_port;
  logic [10:0] desc_len;

  assign desc_err  = bus.ptr_sfifo_dout[15];
  assign desc_port = bus.ptr_sfifo_dout[14:11];
  assign desc_len  = bus.ptr_sfifo_dout[10:0];

  always_comb begin
    state_d = state_q;
    boot_d  = 1'b1;
    drop_d  = drop_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    port_d  = port_q;
    hidx_d  = hidx_q;
    dmac_d  = dmac_q;
    smac_d  = smac_q;
    wr_d    = (state_q == DATA) && !drop_q;

    // Header bytes are OR-ed into fields cleared at descriptor capture.
    if (wr_q) begin
      if (hidx_q < 4'd6) begin
        dmac_d = dmac_q | ({bus.sfifo_dout, 40'h0} >> {hidx_q, 3'b000});
      end else if (hidx_q < 4'd12) begin
        smac_d = smac_q | ({bus.sfifo_dout, 40'h0} >> {hidx_q - 4'd6, 3'b000});
      end
      if (hidx_q != 4'd12) hidx_d = hidx_q + 4'd1;
    end

    case (state_q)
      IDLE: begin
        if (boot_q && !bus.ptr_sfifo_empty && bus.out_space_ok) state_d = PTR_RD;
      end
      PTR_RD: state_d = PTR_CAP;
      PTR_CAP: begin
        len_d   = desc_len;
        port_d  = desc_port;
        drop_d  = desc_err || (desc_len < MIN_L) || (desc_len > MAX_L);
        cnt_d   = '0;
        hidx_d  = '0;
        dmac_d  = '0;
        smac_d  = '0;
        state_d = (desc_len == '0) ? IDLE : DATA;
      end
      DATA: begin
        cnt_d = cnt_q + 11'd1;
        if (cnt_q == len_q - 11'd1) state_d = DRAIN;
      end
      DRAIN: state_d = drop_q ? IDLE : HDR;
      HDR: begin
        if (bus.hdr_ack) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_sys or negedge rstn_sys) begin
    if (!rstn_sys) begin
      state_q <= IDLE;
      boot_q  <= 1'b0;
      drop_q  <= 1'b0;
      wr_q    <= 1'b0;
      cnt_q   <= '0;
      len_q   <= '0;
      port_q  <= '0;
      hidx_q  <= '0;
      dmac_q  <= '0;
      smac_q  <= '0;
    end else begin
      state_q <= state_d;
      boot_q  <= boot_d;
      drop_q  <= drop_d;
      wr_q    <= wr_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      port_q  <= port_d;
      hidx_q  <= hidx_d;
      dmac_q  <= dmac_d;
      smac_q  <= smac_d;
    end
  end

  // Byte k is on sfifo_dout the cycle after its pop, so the strobe cycle
  // forwards it directly; the last byte lands in DRAIN.
  assign bus.ptr_sfifo_rd = (state_q == PTR_RD);
  assign bus.sfifo_rd     = (state_q == DATA);
  assign bus.out_data_wr  = wr_q;
  assign bus.out_data     = wr_q ? bus.sfifo_dout : '0;
  assign bus.out_sof      = wr_q && (hidx_q == '0);
  assign bus.out_eof      = wr_q && (state_q == DRAIN);
  assign bus.hdr_valid    = (state_q == HDR);
  assign bus.hdr_dmac     = dmac_q;
  assign bus.hdr_smac     = smac_q;
  assign bus.hdr_src_port = port_q;
  assign bus.hdr_len      = len_q;
  assign bus.drop_pulse   = ((state_q == PTR_CAP) && (desc_len == '0)) ||
                            ((state_q == DRAIN) && drop_q);

endmodule

// File: tb/tb_frame_hdr_extract.sv
// Directed bench for frame_hdr_extract: table of frames plus hand-written
// sequences for back-pressure, delayed header ack and mid-frame reset.
module tb_frame_hdr_extract;
  logic clk_sys = 1'b0;
  logic rstn_sys;

  frame_hdr_extract_if bus ();

  frame_hdr_extract #(.MIN_LEN(60), .MAX_LEN(1518)) dut (
    .clk_sys  (clk_sys),
    .rstn_sys (rstn_sys),
    .bus      (bus.master)
  );

  always #5 clk_sys = ~clk_sys;

  typedef struct {
    logic [15:0]  desc;
    logic [47:0]  dmac;
    logic [47:0]  smac;
    int unsigned  exp_rd;
    int unsigned  exp_wr;
    int unsigned  exp_drop;
    int unsigned  exp_hdr;
    logic [3:0]   exp_port;
    logic [10:0]  exp_len;
  } vec_t;

  vec_t vecs[8];

  int unsigned checks = 0;
  int unsigned errors = 0;
  bit          auto_ack;

  // FIFO models: registered read, dout valid the cycle after the pop.
  logic [15:0] ptr_q[$];
  logic [7:0]  dat_q[$];
  logic [7:0]  exp_q[$];
  int unsigned underflow = 0;

  always @(posedge clk_sys) begin
    if (bus.ptr_sfifo_rd) begin
      if (ptr_q.size() != 0) bus.ptr_sfifo_dout <= ptr_q.pop_front();
      else underflow++;
    end
    if (bus.sfifo_rd) begin
      if (dat_q.size() != 0) bus.sfifo_dout <= dat_q.pop_front();
      else underflow++;
    end
    bus.ptr_sfifo_empty <= (ptr_q.size() == 0);
  end

  int unsigned cyc = 0;
  int unsigned n_ptr, n_rd, n_wr, n_sof, n_eof, n_drop, n_hdr, n_gap, n_data_err, n_unstable;
  int unsigned first_rd_cyc, last_rd_cyc, first_wr_cyc, ptr_cyc, drop_cyc;
  bit          sof_first, last_eof, prev_wr, prev_hv;
  logic [47:0] cap_dmac, cap_smac;
  logic [3:0]  cap_port;
  logic [10:0] cap_len;

  always @(negedge clk_sys) begin
    cyc++;
    if (rstn_sys) begin
      if (bus.ptr_sfifo_rd) begin n_ptr++; ptr_cyc = cyc; end
      if (bus.sfifo_rd) begin
        if (n_rd == 0) first_rd_cyc = cyc;
        n_rd++;
        last_rd_cyc = cyc;
      end
      if (bus.drop_pulse) begin n_drop++; drop_cyc = cyc; end
      if (bus.out_data_wr) begin
        if (n_wr == 0) begin first_wr_cyc = cyc; sof_first = bus.out_sof; end
        else if (!prev_wr) n_gap++;
        n_wr++;
        if (bus.out_sof) n_sof++;
        if (bus.out_eof) n_eof++;
        last_eof = bus.out_eof;
        if (exp_q.size() != 0) begin
          if (exp_q.pop_front() != bus.out_data) n_data_err++;
        end else n_data_err++;
      end
      if (bus.hdr_valid) begin
        if (!prev_hv) begin
          n_hdr++;
          cap_dmac = bus.hdr_dmac; cap_smac = bus.hdr_smac;
          cap_port = bus.hdr_src_port; cap_len = bus.hdr_len;
        end else if (cap_dmac != bus.hdr_dmac || cap_smac != bus.hdr_smac ||
                     cap_port != bus.hdr_src_port || cap_len != bus.hdr_len) begin
          n_unstable++;
        end
      end
    end
    prev_wr = bus.out_data_wr;
    prev_hv = bus.hdr_valid;
  end

  task automatic chk(input string name, input longint unsigned act, input longint unsigned exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk_sys);
    #1;
  endtask

  task automatic clear_stats();
    n_ptr = 0; n_rd = 0; n_wr = 0; n_sof = 0; n_eof = 0; n_drop = 0; n_hdr = 0;
    n_gap = 0; n_data_err = 0; n_unstable = 0;
    first_rd_cyc = 0; last_rd_cyc = 0; first_wr_cyc = 0; ptr_cyc = 0; drop_cyc = 0;
    sof_first = 1'b0; last_eof = 1'b0;
  endtask

  function automatic logic [7:0] byte_of(input vec_t v, input int i);
    logic [47:0] t;
    logic [7:0]  lo;
    if (i < 6) t = v.dmac >> (8 * (5 - i));
    else if (i < 12) t = v.smac >> (8 * (11 - i));
    else begin
      lo = i[7:0] ^ 8'h5A;
      t  = {40'h0, lo};
    end
    return t[7:0];
  endfunction

  task automatic load_vec(input vec_t v, input bit expect_out);
    logic [7:0] b;
    ptr_q.push_back(v.desc);
    for (int i = 0; i < int'(v.desc[10:0]); i++) begin
      b = byte_of(v, i);
      dat_q.push_back(b);
      if (expect_out) exp_q.push_back(b);
    end
  endtask

  task automatic run_cycles(input int unsigned n);
    for (int unsigned k = 0; k < n; k++) begin
      tick();
      bus.hdr_ack = auto_ack && bus.hdr_valid;
    end
    bus.hdr_ack = 1'b0;
  endtask

  task automatic check_vec(input vec_t v, input int idx);
    chk($sformatf("v%0d ptr_rd count", idx), n_ptr, 1);
    chk($sformatf("v%0d sfifo_rd count", idx), n_rd, v.exp_rd);
    chk($sformatf("v%0d out_data_wr count", idx), n_wr, v.exp_wr);
    chk($sformatf("v%0d drop_pulse count", idx), n_drop, v.exp_drop);
    chk($sformatf("v%0d hdr_valid count", idx), n_hdr, v.exp_hdr);
    chk($sformatf("v%0d data errors", idx), n_data_err, 0);
    if (v.exp_hdr != 0) begin
      chk($sformatf("v%0d hdr_dmac", idx), cap_dmac, v.dmac);
      chk($sformatf("v%0d hdr_smac", idx), cap_smac, v.smac);
      chk($sformatf("v%0d hdr_src_port", idx), cap_port, v.exp_port);
      chk($sformatf("v%0d hdr_len", idx), cap_len, v.exp_len);
    end
    if (v.exp_wr != 0) begin
      chk($sformatf("v%0d sof count", idx), n_sof, 1);
      chk($sformatf("v%0d eof count", idx), n_eof, 1);
      chk($sformatf("v%0d sof on first", idx), sof_first, 1);
      chk($sformatf("v%0d eof on last", idx), last_eof, 1);
      chk($sformatf("v%0d strobe gaps", idx), n_gap, 0);
      chk($sformatf("v%0d rd-to-wr latency", idx), first_wr_cyc - first_rd_cyc, 1);
    end
    if (v.exp_drop != 0 && v.exp_rd != 0)
      chk($sformatf("v%0d drop in DRAIN", idx), drop_cyc, last_rd_cyc + 1);
    if (v.exp_drop != 0 && v.exp_rd == 0)
      chk($sformatf("v%0d drop in PTR_CAP", idx), drop_cyc, ptr_cyc + 1);
  endtask

  initial begin
    int unsigned k, held, rel_cyc;
    vec_t        v;

    vecs[0] = '{16'h103C, 48'h010203040506, 48'h0A0B0C0D0E0F, 60, 60, 0, 1, 4'b0010, 11'd60};
    vecs[1] = '{16'h0828, 48'h111111111111, 48'h222222222222, 40, 0, 1, 0, 4'b0001, 11'd40};
    vecs[2] = '{16'h8040, 48'h333333333333, 48'h444444444444, 64, 0, 1, 0, 4'b0000, 11'd64};
    vecs[3] = '{16'h2000, 48'h0, 48'h0, 0, 0, 1, 0, 4'b0100, 11'd0};
    vecs[4] = '{16'h0840, 48'hDEADBEEF0001, 48'h112233445566, 64, 64, 0, 1, 4'b0001, 11'd64};
    vecs[5] = '{16'h45EE, 48'hA1A2A3A4A5A6, 48'hB1B2B3B4B5B6, 1518, 1518, 0, 1, 4'b1000, 11'd1518};
    vecs[6] = '{16'h45EF, 48'hC1C2C3C4C5C6, 48'hD1D2D3D4D5D6, 1519, 0, 1, 0, 4'b1000, 11'd1519};
    vecs[7] = '{16'h083B, 48'hE1E2E3E4E5E6, 48'hF1F2F3F4F5F6, 59, 0, 1, 0, 4'b0001, 11'd59};

    rstn_sys = 1'b0;
    bus.out_space_ok = 1'b1;
    bus.hdr_ack = 1'b0;
    auto_ack = 1'b1;
    clear_stats();
    repeat (3) tick();
    chk("reset ptr_sfifo_rd", bus.ptr_sfifo_rd, 0);
    chk("reset sfifo_rd", bus.sfifo_rd, 0);
    chk("reset out_data_wr", bus.out_data_wr, 0);
    chk("reset hdr_valid", bus.hdr_valid, 0);
    chk("reset drop_pulse", bus.drop_pulse, 0);
    chk("reset out_data", bus.out_data, 0);
    chk("reset hdr_dmac", bus.hdr_dmac, 0);
    chk("reset hdr_len", bus.hdr_len, 0);
    rstn_sys = 1'b1;
    repeat (2) tick();

    for (int i = 0; i < 8; i++) begin
      clear_stats();
      load_vec(vecs[i], vecs[i].exp_wr != 0);
      run_cycles(vecs[i].exp_rd + 14);
      check_vec(vecs[i], i);
    end

    // Back-pressure: a pending descriptor must wait for out_space_ok.
    clear_stats();
    bus.out_space_ok = 1'b0;
    ptr_q.push_back(16'h2000);
    run_cycles(8);
    chk("space_ok low no pop", n_ptr, 0);
    bus.out_space_ok = 1'b1;
    tick();
    chk("space_ok raise pop latency", bus.ptr_sfifo_rd, 1);
    run_cycles(4);
    chk("space_ok len0 sfifo_rd", n_rd, 0);
    chk("space_ok len0 drop", n_drop, 1);

    // Header ack withheld for 10 cycles with a second descriptor queued.
    clear_stats();
    auto_ack = 1'b0;
    load_vec(vecs[0], 1'b1);
    ptr_q.push_back(16'h2000);
    k = 0;
    while (!bus.hdr_valid && k < 200) begin tick(); k++; end
    chk("hold hdr_valid reached", bus.hdr_valid, 1);
    held = 0;
    repeat (10) begin
      if (bus.hdr_valid) held++;
      tick();
    end
    chk("hold hdr_valid cycles", held, 10);
    chk("hold no second pop", n_ptr, 1);
    chk("hold fields stable", n_unstable, 0);
    chk("hold hdr_dmac", cap_dmac, 48'h010203040506);
    chk("hold hdr_smac", cap_smac, 48'h0A0B0C0D0E0F);
    bus.hdr_ack = 1'b1;
    tick();
    bus.hdr_ack = 1'b0;
    chk("hold hdr_valid drops", bus.hdr_valid, 0);
    k = 1;
    while (!bus.ptr_sfifo_rd && k < 10) begin tick(); k++; end
    chk("hold second pop after ack", (bus.ptr_sfifo_rd == 1'b1) && (k >= 2), 1);
    run_cycles(4);
    chk("hold data errors", n_data_err, 0);
    chk("hold second frame drop", n_drop, 1);
    auto_ack = 1'b1;

    // Reset at byte 30 of a 100-byte frame, then a clean 64-byte frame.
    clear_stats();
    v = vecs[4];
    v.desc = 16'h0864;
    load_vec(v, 1'b1);
    k = 0;
    while (n_wr < 30 && k < 200) begin tick(); k++; end
    chk("mid-frame reached byte 30", n_wr, 30);
    #2 rstn_sys = 1'b0;
    #1;
    chk("async rst ptr_sfifo_rd", bus.ptr_sfifo_rd, 0);
    chk("async rst sfifo_rd", bus.sfifo_rd, 0);
    chk("async rst out_data_wr", bus.out_data_wr, 0);
    chk("async rst out_sof/eof", {bus.out_sof, bus.out_eof}, 0);
    chk("async rst hdr_valid", bus.hdr_valid, 0);
    chk("async rst drop_pulse", bus.drop_pulse, 0);
    chk("async rst out_data", bus.out_data, 0);
    chk("async rst hdr_smac", bus.hdr_smac, 0);
    chk("async rst hdr_src_port", bus.hdr_src_port, 0);
    ptr_q.delete();
    dat_q.delete();
    exp_q.delete();
    clear_stats();
    load_vec(vecs[4], 1'b1);
    repeat (2) tick();
    rstn_sys = 1'b1;
    rel_cyc = cyc;
    run_cycles(64 + 14);
    check_vec(vecs[4], 40);
    chk("first pop after release >= 2 edges", (ptr_cyc - rel_cyc) >= 2, 1);

    chk("fifo underflows", underflow, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
